// File: rtl/vga_pkg.sv
// Nominal 800x600 VGA timing shared by the timing generator and the sync receiver,
// plus the receiver's acquisition state type.
package vga_pkg;

  localparam int unsigned VGA_H_DISPLAY = 800;
  localparam int unsigned VGA_H_FRONT   = 56;
  localparam int unsigned VGA_H_SYNC    = 120;
  localparam int unsigned VGA_H_BACK    = 64;
  localparam int unsigned VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int unsigned VGA_V_DISPLAY = 600;
  localparam int unsigned VGA_V_FRONT   = 37;
  localparam int unsigned VGA_V_SYNC    = 6;
  localparam int unsigned VGA_V_BACK    = 23;
  localparam int unsigned VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int unsigned VGA_LOCK_FRAMES = 2;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} rx_state_t;

endpackage

// File: rtl/vga_rx_edge_detect.sv
// Two-stage input register for the VGA sync/blank pins with edge strobes taken
// between stage 1 and stage 2.
module vga_rx_edge_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic hsync_n,
  input  logic vsync_n,
  input  logic blank_n,
  output logic hs_fall,
  output logic vs_fall,
  output logic blank_rise,
  output logic blank_fall,
  output logic blank_q
);

  logic [2:0] stage1;
  logic [2:0] stage2;

  // NOTE: state registers use non-blocking assignments so stage2 sees the old stage1.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1 <= {hsync_n, vsync_n, blank_n};
      stage2 <= stage1;
    end
  end

  assign hs_fall    = stage2[2] & ~stage1[2];
  assign vs_fall    = stage2[1] & ~stage1[1];
  assign blank_rise = ~stage2[0] & stage1[0];
  assign blank_fall = stage2[0] & ~stage1[0];
  assign blank_q    = stage1[0];

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: measures line/frame timing, locks to the nominal mode and
// recovers pixel coordinates. Optional errCount port under VGA_RX_ERRCNT_EN.
module vga_sync_receiver
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY   = VGA_H_DISPLAY,
  parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
  parameter int unsigned V_DISPLAY   = VGA_V_DISPLAY,
  parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
  parameter int unsigned LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        hSync_n,
  input  logic        vSync_n,
  input  logic        blank_n,
  output logic [10:0] pixelX,
  output logic [9:0]  pixelY,
  output logic        pixelValid,
  output logic        locked,
  output logic        lineStart,
  output logic        frameStart,
  output logic        syncError,
  output logic [11:0] hTotalMeas,
  output logic [10:0] vTotalMeas
`ifdef VGA_RX_ERRCNT_EN
  ,
  output logic [15:0] errCount
`endif
);

  localparam logic [11:0] H_TOTAL_C   = 12'(H_TOTAL);
  localparam logic [10:0] H_LAST_C    = 11'(H_DISPLAY - 1);
  localparam logic [9:0]  V_LAST_C    = 10'(V_DISPLAY - 1);
  localparam logic [10:0] V_TOTAL_C   = 11'(V_TOTAL);
  localparam logic [10:0] V_DISPLAY_C = 11'(V_DISPLAY);
  localparam logic [11:0] WD_LIMIT    = 12'(2 * H_TOTAL);
  localparam logic [2:0]  LOCK_C      = 3'(LOCK_FRAMES);

  logic hs_fall, vs_fall, blank_rise, blank_fall, blank_q;

  vga_rx_edge_detect u_edge (
    .Clock      (Clock),
    .Reset      (Reset),
    .hsync_n    (hSync_n),
    .vsync_n    (vSync_n),
    .blank_n    (blank_n),
    .hs_fall    (hs_fall),
    .vs_fall    (vs_fall),
    .blank_rise (blank_rise),
    .blank_fall (blank_fall),
    .blank_q    (blank_q)
  );

  rx_state_t   state, state_next;
  logic [2:0]  good_frames, good_next;
  logic [11:0] h_meas;
  logic [10:0] line_cnt, act_lines;
  logic        h_primed, frame_bad, wd_fired;
  logic        sync_err;

  logic [11:0] h_len;
  logic [10:0] lines_total, act_total;
  logic        line_fail, frame_fail, wd_hit;

  // Totals include an edge landing in the current cycle, saturating at all-ones.
  assign h_len       = (h_meas == '1) ? h_meas : h_meas + 12'd1;
  assign lines_total = (hs_fall && line_cnt != '1) ? line_cnt + 11'd1 : line_cnt;
  assign act_total   = (blank_fall && act_lines != '1) ? act_lines + 11'd1 : act_lines;

  assign line_fail  = (state != SEARCH) &&
                      ((hs_fall && h_primed && h_len != H_TOTAL_C) ||
                       (blank_fall && pixelX != H_LAST_C));
  assign frame_fail = frame_bad || line_fail ||
                      (lines_total != V_TOTAL_C) || (act_total != V_DISPLAY_C);
  assign wd_hit     = (state != SEARCH) && !wd_fired && !hs_fall && (h_meas >= WD_LIMIT);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_next = state;
    good_next  = good_frames;
    sync_err   = 1'b0;
    unique case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_next = MEASURE;
          good_next  = '0;
        end
      end
      MEASURE: begin
        if (wd_hit) begin
          state_next = SEARCH;
          sync_err   = 1'b1;
        end else if (vs_fall) begin
          if (frame_fail) begin
            good_next = '0;
            sync_err  = 1'b1;
          end else begin
            good_next = good_frames + 3'd1;
            if (good_frames + 3'd1 == LOCK_C) state_next = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (wd_hit || line_fail || (vs_fall && frame_fail)) begin
          state_next = SEARCH;
          sync_err   = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= SEARCH;
      good_frames <= '0;
    end else begin
      state       <= state_next;
      good_frames <= good_next;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      h_meas     <= '0;
      line_cnt   <= '0;
      act_lines  <= '0;
      h_primed   <= 1'b0;
      frame_bad  <= 1'b0;
      wd_fired   <= 1'b0;
      pixelX     <= '0;
      pixelY     <= '0;
      pixelValid <= 1'b0;
      locked     <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
      syncError  <= 1'b0;
      hTotalMeas <= '0;
      vTotalMeas <= '0;
    end else begin
      if (hs_fall) begin
        h_meas     <= '0;
        hTotalMeas <= h_len;
      end else if (h_meas != '1) begin
        h_meas <= h_meas + 12'd1;
      end

      if (vs_fall) begin
        vTotalMeas <= lines_total;
        line_cnt   <= hs_fall ? 11'd1 : 11'd0;
        act_lines  <= '0;
      end else begin
        line_cnt  <= lines_total;
        act_lines <= act_total;
      end

      if (blank_rise)                       pixelX <= '0;
      else if (blank_q && pixelX != '1)     pixelX <= pixelX + 11'd1;

      if (vs_fall)                          pixelY <= '0;
      else if (blank_fall && pixelY < V_LAST_C) pixelY <= pixelY + 10'd1;

      // The first line after SEARCH may have started mid-line, so its length is not trusted.
      if (state == SEARCH)   h_primed <= 1'b0;
      else if (hs_fall)      h_primed <= 1'b1;

      if (state == SEARCH || vs_fall) frame_bad <= 1'b0;
      else if (line_fail)             frame_bad <= 1'b1;

      if (hs_fall)      wd_fired <= 1'b0;
      else if (wd_hit)  wd_fired <= 1'b1;

      lineStart  <= hs_fall;
      frameStart <= vs_fall;
      syncError  <= sync_err;
      locked     <= (state_next == LOCKED);
      pixelValid <= (state_next == LOCKED) && blank_q;
    end
  end

`ifdef VGA_RX_ERRCNT_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                              errCount <= '0;
    else if (sync_err && errCount != '1)    errCount <= errCount + 16'd1;
  end
`endif

endmodule
